// File: rtl/clahe_pkg.sv
// Shared CLAHE histogram constants, accumulate FSM states and histogram address packing.
package clahe_pkg;

    localparam int TILE_NUM    = 16;
    localparam int BIN_NUM     = 256;
    localparam int COUNT_W     = 16;
    localparam int TILE_W      = 4;
    localparam int BIN_W       = 8;
    localparam int HIST_ADDR_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        DRAIN,
        SWAP,
        CLEAR
    } hist_state_t;

    function automatic logic [HIST_ADDR_W-1:0] hist_addr(input logic [TILE_W-1:0] tile,
                                                         input logic [BIN_W-1:0]  bin);
        return {tile, bin};
    endfunction

endpackage

// File: rtl/clahe_hist_ram.sv
// Two-bank histogram store: accumulate/clear port (read + write), independent read-only port.
// Both reads are registered; a same-cycle read and write to one address returns the old value.
module clahe_hist_ram #(
    parameter int DW = 16,
    parameter int AW = 12
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          a_bank,
    input  logic [AW-1:0] a_raddr,
    input  logic          a_we,
    input  logic [AW-1:0] a_waddr,
    input  logic [DW-1:0] a_wdat,
    output logic [DW-1:0] a_q,
    input  logic          b_en,
    input  logic          b_bank,
    input  logic [AW-1:0] b_addr,
    output logic [DW-1:0] b_q
);

    logic [DW-1:0] mem [0:2**(AW+1)-1];

    always_ff @(posedge pclk) begin
        a_q <= mem[{a_bank, a_raddr}];
        if (a_we) begin
            mem[{a_bank, a_waddr}] <= a_wdat;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            b_q <= '0;
        end else if (b_en) begin
            b_q <= mem[{b_bank, b_addr}];
        end
    end

endmodule

// File: rtl/clahe_hist_stat.sv
// Per-tile luma histogram with ping-pong banks; CLAHE_HIST_SAT_EN selects saturating bins.
// Latency: pixel to bank write 3 cycles, rd_en to rd_data 1 cycle, vsync fall to hist_ready 4 cycles.
// No backpressure: one pixel per cycle; pixels arriving while a bank is cleared are dropped into overrun.
module clahe_hist_stat #(
    parameter int TILE_NUM = 16,
    parameter int BIN_NUM  = 256,
    parameter int COUNT_W  = 16
) (
    input  logic                        pclk,
    input  logic                        rst,
    input  logic                        in_href,
    input  logic                        in_vsync,
    input  logic [7:0]                  in_y,
    input  logic [$clog2(TILE_NUM)-1:0] tile_idx,
    input  logic                        rd_en,
    input  logic [$clog2(TILE_NUM)-1:0] rd_tile,
    input  logic [$clog2(BIN_NUM)-1:0]  rd_bin,
    output logic [COUNT_W-1:0]          rd_data,
    output logic                        rd_valid,
    output logic                        hist_ready,
    output logic                        rd_bank,
    output logic                        busy_clear,
    output logic                        overrun
);

    import clahe_pkg::*;

    localparam int AW = HIST_ADDR_W;

    function automatic logic [COUNT_W-1:0] cnt_inc(input logic [COUNT_W-1:0] v);
`ifdef CLAHE_HIST_SAT_EN
        return (&v) ? v : v + COUNT_W'(1);
`else
        return v + COUNT_W'(1);
`endif
    endfunction

    hist_state_t        state, state_nxt;
    logic               vsync_d, vsync_pend, init_pend, wr_bank;
    logic               vs_rise, vs_fall;
    logic [1:0]         drain_cnt;
    logic [AW-1:0]      clr_addr;

    logic               p0_vld, p1_vld, p1_fwd, lw_vld;
    logic [AW-1:0]      p0_addr, p1_addr, lw_addr;
    logic [COUNT_W-1:0] p1_fwd_val, p1_new, lw_dat, ram_q;
    logic               hit_s2, fwd_hit;
    logic [COUNT_W-1:0] fwd_val;

    logic               a_we;
    logic [AW-1:0]      a_waddr;
    logic [COUNT_W-1:0] a_wdat;

    assign vs_rise = in_vsync & ~vsync_d;
    assign vs_fall = ~in_vsync & vsync_d;
    assign rd_bank = ~wr_bank;

    always_comb begin
        state_nxt  = state;
        hist_ready = 1'b0;
        busy_clear = 1'b0;
        case (state)
            IDLE: begin
                if (init_pend) begin
                    state_nxt = CLEAR;
                end else if (vs_rise) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                if (vs_fall) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == 2'd2) begin
                    state_nxt = SWAP;
                end
            end
            SWAP: begin
                hist_ready = 1'b1;
                state_nxt  = CLEAR;
            end
            CLEAR: begin
                busy_clear = 1'b1;
                if (&clr_addr) begin
                    state_nxt = ((vsync_pend || vs_rise) && in_vsync) ? ACC : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // S2 value: forward from the in-flight or just-written count, else RAM data.
    assign p1_new  = cnt_inc(p1_fwd ? p1_fwd_val : ram_q);
    assign hit_s2  = p1_vld && (p1_addr == p0_addr);
    assign fwd_hit = hit_s2 || (lw_vld && (lw_addr == p0_addr));
    assign fwd_val = hit_s2 ? p1_new : lw_dat;

    always_comb begin
        a_we    = p1_vld;
        a_waddr = p1_addr;
        a_wdat  = p1_new;
        if (state == CLEAR) begin
            a_we    = 1'b1;
            a_waddr = clr_addr;
            a_wdat  = '0;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            vsync_d    <= 1'b0;
            vsync_pend <= 1'b0;
            init_pend  <= 1'b1;
            wr_bank    <= 1'b0;
            drain_cnt  <= 2'd0;
            clr_addr   <= '0;
            overrun    <= 1'b0;
            p0_vld     <= 1'b0;
            p0_addr    <= '0;
            p1_vld     <= 1'b0;
            p1_addr    <= '0;
            p1_fwd     <= 1'b0;
            p1_fwd_val <= '0;
            lw_vld     <= 1'b0;
            lw_addr    <= '0;
            lw_dat     <= '0;
            rd_valid   <= 1'b0;
        end else begin
            state   <= state_nxt;
            vsync_d <= in_vsync;
            // Remembers a frame start seen while the write bank is not yet usable.
            if (state_nxt == ACC || vs_fall) begin
                vsync_pend <= 1'b0;
            end else if (vs_rise) begin
                vsync_pend <= 1'b1;
            end
            if (state == IDLE) begin
                init_pend <= 1'b0;
            end
            if (state == SWAP) begin
                wr_bank <= ~wr_bank;
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            clr_addr  <= (state == CLEAR) ? clr_addr + AW'(1) : '0;
            if (in_href && in_vsync && (state == CLEAR || vsync_pend)) begin
                overrun <= 1'b1;
            end
            p0_vld     <= (state == ACC) && in_href;
            p0_addr    <= hist_addr(tile_idx, in_y);
            p1_vld     <= p0_vld;
            p1_addr    <= p0_addr;
            p1_fwd     <= fwd_hit;
            p1_fwd_val <= fwd_val;
            lw_vld     <= a_we;
            lw_addr    <= a_waddr;
            lw_dat     <= a_wdat;
            rd_valid   <= rd_en;
        end
    end

    clahe_hist_ram #(
        .DW (COUNT_W),
        .AW (AW)
    ) u_ram (
        .pclk    (pclk),
        .rst     (rst),
        .a_bank  (wr_bank),
        .a_raddr (p0_addr),
        .a_we    (a_we),
        .a_waddr (a_waddr),
        .a_wdat  (a_wdat),
        .a_q     (ram_q),
        .b_en    (rd_en),
        .b_bank  (rd_bank),
        .b_addr  (hist_addr(rd_tile, rd_bin)),
        .b_q     (rd_data)
    );

endmodule

// File: tb/tb_clahe_hist_stat.sv
// Self-checking bench for clahe_hist_stat: directed frames plus random frames against a bin-count model.
module tb_clahe_hist_stat;

    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          pclk = 1'b0;
    logic          rst = 1'b1;
    logic          in_href = 1'b0;
    logic          in_vsync = 1'b0;
    logic [7:0]    in_y = '0;
    logic [3:0]    tile_idx = '0;
    logic          rd_en = 1'b0;
    logic [3:0]    rd_tile = '0;
    logic [7:0]    rd_bin = '0;
    logic [CW-1:0] rd_data;
    logic          rd_valid, hist_ready, rd_bank, busy_clear, overrun;

    int checks = 0;
    int errors = 0;
    int bc_cnt = 0;
    int cur [4096];
    int rdm [4096];
    bit seen [4096];
    int touched [$];
    bit rdm_ok = 1'b0;
    bit exp_bank = 1'b1;

    always #5 pclk = ~pclk;

    clahe_hist_stat #(
        .TILE_NUM (16),
        .BIN_NUM  (256),
        .COUNT_W  (CW)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .in_href    (in_href),
        .in_vsync   (in_vsync),
        .in_y       (in_y),
        .tile_idx   (tile_idx),
        .rd_en      (rd_en),
        .rd_tile    (rd_tile),
        .rd_bin     (rd_bin),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .hist_ready (hist_ready),
        .rd_bank    (rd_bank),
        .busy_clear (busy_clear),
        .overrun    (overrun)
    );

    task automatic chk(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counter value a bin must show after n hits.
    function automatic int expc(int n);
`ifdef CLAHE_HIST_SAT_EN
        return (n > CMAX) ? CMAX : n;
`else
        return n % (CMAX + 1);
`endif
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
        if (busy_clear) bc_cnt++;
    endtask

    task automatic idle(int n);
        in_href = 1'b0;
        repeat (n) tick();
    endtask

    task automatic px(int t, int y, bit cnt);
        int a;
        a = t * 256 + y;
        in_href  = 1'b1;
        tile_idx = t[3:0];
        in_y     = y[7:0];
        if (cnt) begin
            if (!seen[a]) begin
                seen[a] = 1'b1;
                touched.push_back(a);
            end
            cur[a]++;
        end
        tick();
    endtask

    task automatic start_frame();
        foreach (cur[i]) begin
            cur[i]  = 0;
            seen[i] = 1'b0;
        end
        touched.delete();
        in_vsync = 1'b1;
        idle(2);
    endtask

    task automatic rd(int a, output int d);
        rd_en   = 1'b1;
        rd_tile = a[11:8];
        rd_bin  = a[7:0];
        tick();
        chk("rd_valid", int'(rd_valid), 1);
        d = int'(rd_data);
        rd_en = 1'b0;
    endtask

    task automatic end_frame();
        int n;
        int old0;
        in_href = 1'b0;
        tick();
        in_vsync = 1'b0;
        n = 0;
        while (!hist_ready && n < 12) begin
            tick();
            n++;
        end
        chk("rdy_lat", n, 4);
        bc_cnt = 0;
        old0 = rdm[0];
        rd_en   = 1'b1;
        rd_tile = 4'd0;
        rd_bin  = 8'd0;
        tick();
        if (rdm_ok) chk("swap_rd_old_bank", int'(rd_data), expc(old0));
        rd_en = 1'b0;
        chk("rdy_pulse", int'(hist_ready), 0);
        exp_bank = ~exp_bank;
        chk("rd_bank", int'(rd_bank), int'(exp_bank));
        chk("busy_after_swap", int'(busy_clear), 1);
        rdm    = cur;
        rdm_ok = 1'b1;
    endtask

    task automatic verify();
        int d;
        int a;
        foreach (touched[i]) begin
            rd(touched[i], d);
            chk($sformatf("bin_%03h", touched[i]), d, expc(rdm[touched[i]]));
        end
        repeat (6) begin
            a = int'($urandom_range(0, 4095));
            rd(a, d);
            chk($sformatf("rnd_%03h", a), d, expc(rdm[a]));
        end
    endtask

    task automatic wait_clear();
        int n;
        n = 0;
        while (!busy_clear && n < 8) begin
            tick();
            n++;
        end
        n = 0;
        while (busy_clear && n < 5000) begin
            tick();
            n++;
        end
        chk("clr_len", bc_cnt, 4096);
    endtask

    task automatic check_reset_outputs();
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_hist_ready", int'(hist_ready), 0);
        chk("rst_busy_clear", int'(busy_clear), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_rd_bank", int'(rd_bank), 1);
    endtask

    initial begin
        int d;
        int t;
        int y;
        bit hot;

        repeat (3) @(posedge pclk);
        #1;
        check_reset_outputs();
        rst    = 1'b0;
        bc_cnt = 0;
        wait_clear();

        // 100 identical pixels: counter exceeds the bin width
        start_frame();
        repeat (100) px(5, 'h10, 1'b1);
        end_frame();
        verify();
        rd(5 * 256 + 'h11, d);
        chk("f1_neighbour_bin", d, 0);
        chk("f1_no_overrun", int'(overrun), 0);
        wait_clear();

        // Back-to-back and spaced repeats through the forwarding paths
        start_frame();
        px(3, 'h40, 1'b1);
        px(3, 'h40, 1'b1);
        px(3, 'h40, 1'b1);
        px(3, 'h41, 1'b1);
        px(3, 'h40, 1'b1);
        idle(1);
        px(9, 'h01, 1'b1);
        idle(1);
        px(9, 'h02, 1'b1);
        idle(1);
        px(9, 'h01, 1'b1);
        end_frame();
        verify();
        rd(3 * 256 + 'h40, d);
        chk("haz_A", d, 4);
        rd(3 * 256 + 'h41, d);
        chk("haz_B", d, 1);
        rd(9 * 256 + 'h01, d);
        chk("spaced_A", d, 2);
        wait_clear();

        // Ping-pong: second frame must not accumulate on the first
        start_frame();
        repeat (7) px(0, 0, 1'b1);
        end_frame();
        verify();
        rd(0, d);
        chk("pp_first", d, 7);
        wait_clear();
        start_frame();
        repeat (3) px(0, 0, 1'b1);
        end_frame();
        verify();
        rd(0, d);
        chk("pp_second", d, 3);
        wait_clear();

        repeat (2) begin
            start_frame();
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    idle(1);
                end else begin
                    hot = 1'($urandom_range(0, 1));
                    t   = hot ? 0 : int'($urandom_range(0, 15));
                    y   = hot ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
                    px(t, y, 1'b1);
                end
            end
            end_frame();
            verify();
            wait_clear();
        end

        // Frame start during a clear: pixels dropped, clear runs to completion
        start_frame();
        repeat (4) px(1, 'h22, 1'b1);
        end_frame();
        idle(10);
        in_vsync = 1'b1;
        repeat (20) px(2, 'h20, 1'b0);
        idle(1);
        chk("overrun_set", int'(overrun), 1);
        chk("clear_not_aborted", int'(busy_clear), 1);
        verify();
        wait_clear();
        start_frame();
        repeat (5) px(2, 'h20, 1'b1);
        end_frame();
        verify();
        rd(2 * 256 + 'h20, d);
        chk("ovr_frame_cnt", d, 5);
        chk("overrun_sticky", int'(overrun), 1);
        wait_clear();

        // Reset in the middle of a frame
        start_frame();
        repeat (10) px(7, 'h70, 1'b0);
        in_href  = 1'b0;
        in_vsync = 1'b0;
        rst      = 1'b1;
        #1;
        check_reset_outputs();
        rdm_ok   = 1'b0;
        exp_bank = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        rst    = 1'b0;
        bc_cnt = 0;
        wait_clear();
        start_frame();
        repeat (3) px(7, 'h70, 1'b1);
        end_frame();
        verify();
        rd(7 * 256 + 'h70, d);
        chk("post_rst_cnt", d, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clahe_hist_stat.md
# clahe_hist_stat

Per-tile luminance histogram accumulator for the CLAHE pipeline. Sits directly downstream of the coordinate/tile-locating stage: consumes the pixel luma plus its `tile_idx` and builds 16 tiles × 256 bins of counts for the current frame. Uses ping-pong banks: at frame end the completed bank is handed to the clip/CDF stage through a read port, while the other bank is cleared and then accumulates the next frame.

## Interface
Parameters:
- `TILE_NUM`, 16: number of tiles; tile index width is 4.
- `BIN_NUM`, 256: bins per tile; luma width is 8.
- `COUNT_W`, 16: bin counter width; holds the max tile population of 320×180 = 57600.

Ports:
- `pclk` in 1: pixel clock; the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `in_href` in 1: pixel valid; aligned with `in_y` and `tile_idx`.
- `in_vsync` in 1: frame valid, high during the active frame.
- `in_y` in 8: pixel luma, which selects the bin.
- `tile_idx` in 4: tile of the current pixel.
- `rd_en` in 1: read request on the completed bank.
- `rd_tile` in 4: read tile.
- `rd_bin` in 8: read bin.
- `rd_data` out COUNT_W: count returned for the request.
- `rd_valid` out 1: qualifies `rd_data`.
- `hist_ready` out 1: one-cycle pulse; the read bank now holds a completed frame.
- `rd_bank` out 1: index of the bank currently readable.
- `busy_clear` out 1: high while the write bank is being cleared.
- `overrun` out 1: sticky; set when pixels are dropped during a clear.

## Operation
- FSM states: `IDLE`, `ACC`, `DRAIN`, `SWAP`, `CLEAR`.
- `IDLE` → `ACC` on the `in_vsync` rising edge.
- `ACC` → `DRAIN` on the `in_vsync` falling edge.
- `DRAIN` lasts 3 cycles so the pipeline empties, then goes to `SWAP`.
- `SWAP` (1 cycle):
  - toggles `wr_bank`; `rd_bank = ~wr_bank`;
  - pulses `hist_ready`;
  - goes to `CLEAR`.
- `CLEAR`:
  - writes zero to all 4096 addresses of the new write bank, one per cycle, address counter 0..4095;
  - then goes to `IDLE`.
- A `in_vsync` rising edge during `CLEAR` does not abort the clear:
  - FSM goes to `ACC` after the clear completes;
  - `in_href` pixels arriving before that are dropped and set `overrun`;
  - `overrun` clears only on `rst`.
- Accumulate pipeline, active in `ACC` with `in_href`=1:
  - S0 registers the address `{tile_idx, in_y}` (12 bits);
  - S1 issues the RAM read;
  - S2 computes count+1 and writes it back.
- Read-after-write hazard:
  - If S1's address equals the address in S2, S2 takes S2's just-computed value instead of RAM data.
  - If it equals the address written the previous cycle, S2 takes the last write value.
  - N back-to-back identical pixels must yield exactly +N.
- Arithmetic:
  - increment width is COUNT_W;
  - overflow behaviour depends on the macro below.
- Read port:
  - always addresses `rd_bank` at `{rd_tile, rd_bin}`;
  - is independent of the accumulate FSM;
  - can be served in any state.
- `rd_bank` only changes in `SWAP`. A read issued in the same cycle as `SWAP` returns the old bank.

## Timing
- Reset values:
  - all outputs 0;
  - `wr_bank`=0, `rd_bank`=1, FSM=`IDLE`;
  - RAM contents undefined; the first frame's bank is cleared by a reset-triggered `CLEAR` pass of 4096 cycles before `IDLE`, with `busy_clear`=1.
- Pixel to RAM write latency: 3 cycles. Throughput: one pixel per cycle, no stalls.
- `rd_en` to `rd_valid`/`rd_data`: 1 cycle. `rd_valid` is `rd_en` delayed by one cycle.
- Frame end to `hist_ready`: `in_vsync` falling edge plus 4 cycles (3 `DRAIN` cycles, then the `SWAP` cycle).
- `busy_clear` is high for exactly 4096 cycles following `SWAP`.
- Reset asserted mid-frame or mid-clear:
  - immediate return to reset values;
  - restart the reset clear pass.

## Configuration
- `CLAHE_HIST_SAT_EN` defined: a bin at all-ones stays at all-ones (saturating increment).
- Not defined: the counter wraps modulo 2^COUNT_W.
- In both cases the forwarding path uses the same increment function.

## Structure
- Shared package `clahe_pkg`:
  - `TILE_NUM`, `BIN_NUM`, `COUNT_W`, `HIST_ADDR_W`=12;
  - FSM state enum;
  - the address-pack function `{tile, bin}`.
- Sub-module `clahe_hist_ram`:
  - two banks of 4096×COUNT_W;
  - one write/read port for accumulate/clear;
  - one read-only port for `rd_*`;
  - registered read.
- Top holds the FSM, pipeline, forwarding and flags.

## Test plan
- Single frame, all pixels luma 0x10 in tile 5, 100 pixels → after `hist_ready`, `rd(5, 0x10)`=100 and `rd(5, 0x11)`=0.
- Back-to-back hazard: pattern A,A,A,B,A on the same tile → bin A=4, bin B=1. Also ≥1-cycle-spaced repeats A,B,A → A=2.
- Ping-pong: frame 1 fills bin (0,0)=7, frame 2 fills (0,0)=3 → read after each `hist_ready` returns 7 then 3, with no accumulation across frames.
- Early vsync during `CLEAR`: raise `in_vsync` with href 10 cycles into the clear → `overrun`=1, dropped pixels not counted, clear completes (4096 `busy_clear` cycles).
- Overflow with COUNT_W=4, 20 identical pixels → 15 with `CLAHE_HIST_SAT_EN`, 4 without.
- Reset mid-frame → all outputs 0 next edge, `busy_clear` high for 4096 cycles, then the next frame counts from zero.
